bp_me_io_cmd_arbiter: RTL

Shares one single-beat bp_cce_mem_msg_s command/response channel (e.g. the host-side load link feeding bp_me_cce_to_mem_link_bidir) among num_req_p independent requesters such as the NBF loader, the CCE config loader and debug agents. Commands are granted round-robin. Each requester's ID is recorded in an in-order tag FIFO, and every response is steered back to the requester at the FIFO head. This replaces fixed mutex multiplexing and lets loaders run concurrently.

---
 rtl/bp_me_io_cmd_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bp_me_io_cmd_arbiter.sv
// bp_me_io_cmd_arbiter
//   Shares one single-beat command/response channel among num_req_p
//   requesters. Commands are granted round-robin; the ID of every issued
//   command is pushed into an in-order tag FIFO, and each returning response
//   is steered to the requester whose tag sits at the FIFO head.
// Ports:
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   req_cmd_i/_v_i/_ready_o    per-requester command slots (slot i at i*msg_width_p)
//   cmd_o/_v_o, cmd_ready_i    granted command toward downstream
//   resp_i, resp_v_i, resp_yumi_o  downstream response, consumed on yumi
//   req_resp_o/_v_o/_ready_i   response broadcast with one-hot per-requester valid
//   error_o                    sticky: a response arrived with nothing outstanding
module bp_me_io_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 512,
  parameter int max_outstanding_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0]   req_cmd_i,
  input  logic [num_req_p-1:0]               req_cmd_v_i,
  output logic [num_req_p-1:0]               req_cmd_ready_o,
  output logic [msg_width_p-1:0]             cmd_o,
  output logic                               cmd_v_o,
  input  logic                               cmd_ready_i,
  input  logic [msg_width_p-1:0]             resp_i,
  input  logic                               resp_v_i,
  output logic                               resp_yumi_o,
  output logic [msg_width_p-1:0]             req_resp_o,
  output logic [num_req_p-1:0]               req_resp_v_o,
  input  logic [num_req_p-1:0]               req_resp_ready_i,
  output logic                               error_o
);

  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

  localparam logic [id_width_lp-1:0]  id_last_lp  = id_width_lp'(num_req_p - 1);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(max_outstanding_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(max_outstanding_p);

  logic [id_width_lp-1:0]  rr_ptr_r;
  logic [id_width_lp-1:0]  tag_mem_r [max_outstanding_p];
  logic [ptr_width_lp-1:0] wr_ptr_r;
  logic [ptr_width_lp-1:0] rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    error_r;

  logic                    can_issue_s;
  logic                    nonempty_s;
  logic                    hi_found_s;
  logic [id_width_lp-1:0]  hi_grant_s;
  logic [id_width_lp-1:0]  lo_grant_s;
  logic [id_width_lp-1:0]  grant_s;
  logic [id_width_lp-1:0]  rr_next_s;
  logic                    cmd_v_s;
  logic [msg_width_p-1:0]  cmd_s;
  logic [num_req_p-1:0]    cmd_ready_s;
  logic                    push_s;
  logic [id_width_lp-1:0]  head_s;
  logic [num_req_p-1:0]    resp_v_s;
  logic                    pop_s;

  assign can_issue_s = (count_r != cnt_full_lp);
  assign nonempty_s  = (count_r != {cnt_width_lp{1'b0}});

  // Round-robin search: the lowest valid index at or above rr_ptr_r wins;
  // failing that, the lowest valid index overall (wrap-around).
  always_comb begin
    hi_found_s = 1'b0;
    hi_grant_s = {id_width_lp{1'b0}};
    lo_grant_s = {id_width_lp{1'b0}};
    // Descending scan so the lowest matching index is the last assignment.
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (req_cmd_v_i[i]) begin
        lo_grant_s = id_width_lp'(i);
        if (i >= int'(rr_ptr_r)) begin
          hi_found_s = 1'b1;
          hi_grant_s = id_width_lp'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_grant_s = lo_grant_s;
      end
    end
    if (hi_found_s) begin
      grant_s = hi_grant_s;
    end else begin
      grant_s = lo_grant_s;
    end
    if (grant_s == id_last_lp) begin
      rr_next_s = {id_width_lp{1'b0}};
    end else begin
      rr_next_s = grant_s + id_width_lp'(1);
    end
  end

  // Downstream command mux and per-requester accept.
  always_comb begin
    cmd_v_s     = can_issue_s & (|req_cmd_v_i);
    cmd_s       = {msg_width_p{1'b0}};
    cmd_ready_s = {num_req_p{1'b0}};
    for (int i = 0; i < num_req_p; i++) begin
      if (cmd_v_s && (grant_s == id_width_lp'(i))) begin
        cmd_s = req_cmd_i[i*msg_width_p +: msg_width_p];
      end else begin
        cmd_s = cmd_s;
      end
      cmd_ready_s[i] = can_issue_s & cmd_ready_i & (grant_s == id_width_lp'(i)) & req_cmd_v_i[i];
    end
    push_s = cmd_v_s & cmd_ready_i;
  end

  // Response steering to the requester whose tag is at the FIFO head.
  always_comb begin
    head_s = tag_mem_r[rd_ptr_r];
    for (int i = 0; i < num_req_p; i++) begin
      resp_v_s[i] = resp_v_i & nonempty_s & (head_s == id_width_lp'(i));
    end
    pop_s = |(resp_v_s & req_resp_ready_i);
  end

  // Arbitration pointer, tag FIFO and sticky error state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= {id_width_lp{1'b0}};
      wr_ptr_r <= {ptr_width_lp{1'b0}};
      rd_ptr_r <= {ptr_width_lp{1'b0}};
      count_r  <= {cnt_width_lp{1'b0}};
      error_r  <= 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) begin
        tag_mem_r[i] <= {id_width_lp{1'b0}};
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_s;
        rr_ptr_r            <= rr_next_s;
        wr_ptr_r            <= (wr_ptr_r == ptr_last_lp) ? {ptr_width_lp{1'b0}}
                                                         : wr_ptr_r + ptr_width_lp'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == ptr_last_lp) ? {ptr_width_lp{1'b0}}
                                              : rd_ptr_r + ptr_width_lp'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + cnt_width_lp'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - cnt_width_lp'(1);
      end else begin
        count_r <= count_r;
      end
      // A response with nothing outstanding is left unconsumed and flagged.
      if (resp_v_i && !nonempty_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
    end
  end

  assign req_cmd_ready_o = cmd_ready_s;
  assign cmd_o           = cmd_s;
  assign cmd_v_o         = cmd_v_s;
  assign resp_yumi_o     = pop_s;
  assign req_resp_o      = resp_i;
  assign req_resp_v_o    = resp_v_s;
  assign error_o         = error_r;

endmodule
